isodata_point_loader: RTL and testbench

ISODATA_POINT_LOADER -- requirements
Module: isodata_point_loader

---
 rtl/isodata_pkg.sv | 17 +
 rtl/isodata_point_loader.sv | 158 +++++++++++++++
 tb/tb_isodata_point_loader.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/isodata_pkg.sv
// Shared types and frame-length helper for the ISODATA point loader.
// The frame length derives from the cluster and point counts, so every user computes it the same way.
package isodata_pkg;

    typedef enum logic [2:0] {
        LOAD_CTR  = 3'd0,
        LOAD_PTS  = 3'd1,
        KICK      = 3'd2,
        WAIT_DONE = 3'd3,
        DRAIN     = 3'd4
    } state_t;

    function automatic int frame_len(input int num_clusters, input int num_points);
        return num_clusters + num_points;
    endfunction

endpackage

// File: rtl/isodata_point_loader.sv
// Streams one frame of initial centers and points into register arrays and starts the accelerator.
// Malformed frames are flagged with frame_err and never start the accelerator.
module isodata_point_loader
    import isodata_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_POINTS   = 128,
    parameter int NUM_CLUSTERS = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    // Handshake: a beat transfers on a rising edge where s_valid && s_ready.
    // s_valid is not required to stay up; s_ready depends only on state.
    input  logic                                    s_valid,
    output logic                                    s_ready,
    input  logic [DATA_WIDTH-1:0]                   s_x,
    input  logic [DATA_WIDTH-1:0]                   s_y,
    input  logic                                    s_last,
    output logic [NUM_CLUSTERS-1:0][DATA_WIDTH-1:0] centers_x,
    output logic [NUM_CLUSTERS-1:0][DATA_WIDTH-1:0] centers_y,
    output logic [NUM_POINTS-1:0][DATA_WIDTH-1:0]   points_x,
    output logic [NUM_POINTS-1:0][DATA_WIDTH-1:0]   points_y,
    output logic                                    acc_start,
    input  logic                                    acc_done,
    output logic                                    busy,
    output logic                                    frame_err,
    output state_t                                  dbg_state
);

    localparam int CW = (NUM_CLUSTERS > 1) ? $clog2(NUM_CLUSTERS) : 1;
    localparam int PW = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1;
    localparam int FRAME_LEN = frame_len(NUM_CLUSTERS, NUM_POINTS);
    localparam logic [CW-1:0] CTR_LAST = CW'(NUM_CLUSTERS - 1);
    localparam logic [PW-1:0] PT_LAST  = PW'(FRAME_LEN - NUM_CLUSTERS - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] ctr_idx;
    logic [PW-1:0] pt_idx;
    logic          wr_ctr, wr_pt, inc_ctr, inc_pt, clr_idx;
    logic          err_nxt, busy_set, busy_clr;
    logic          frame_err_q, busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD_CTR;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        acc_start = 1'b0;
        wr_ctr    = 1'b0;
        wr_pt     = 1'b0;
        inc_ctr   = 1'b0;
        inc_pt    = 1'b0;
        clr_idx   = 1'b0;
        err_nxt   = 1'b0;
        busy_set  = 1'b0;
        busy_clr  = 1'b0;
        case (state)
            LOAD_CTR: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    wr_ctr   = 1'b1;
                    busy_set = 1'b1;
                    if (s_last) begin
                        // Every center beat precedes the final beat, so s_last here is early.
                        err_nxt  = 1'b1;
                        clr_idx  = 1'b1;
                        busy_clr = 1'b1;
                    end else if (ctr_idx == CTR_LAST) begin
                        state_nxt = LOAD_PTS;
                    end else begin
                        inc_ctr = 1'b1;
                    end
                end
            end
            LOAD_PTS: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    wr_pt = 1'b1;
                    if (pt_idx == PT_LAST) begin
                        if (s_last) begin
                            state_nxt = KICK;
                        end else begin
                            err_nxt   = 1'b1;
                            state_nxt = DRAIN;
                        end
                    end else if (s_last) begin
                        err_nxt   = 1'b1;
                        clr_idx   = 1'b1;
                        busy_clr  = 1'b1;
                        state_nxt = LOAD_CTR;
                    end else begin
                        inc_pt = 1'b1;
                    end
                end
            end
            KICK: begin
                acc_start = 1'b1;
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (acc_done) begin
                    clr_idx   = 1'b1;
                    busy_clr  = 1'b1;
                    state_nxt = LOAD_CTR;
                end
            end
            DRAIN: begin
                s_ready = 1'b1;
                if (s_valid && s_last) begin
                    clr_idx   = 1'b1;
                    busy_clr  = 1'b1;
                    state_nxt = LOAD_CTR;
                end
            end
            default: state_nxt = LOAD_CTR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctr_idx     <= '0;
            pt_idx      <= '0;
            centers_x   <= '0;
            centers_y   <= '0;
            points_x    <= '0;
            points_y    <= '0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            if (clr_idx) begin
                ctr_idx <= '0;
                pt_idx  <= '0;
            end else begin
                if (inc_ctr) ctr_idx <= ctr_idx + CW'(1);
                if (inc_pt)  pt_idx  <= pt_idx + PW'(1);
            end
            if (wr_ctr) begin
                centers_x[ctr_idx] <= s_x;
                centers_y[ctr_idx] <= s_y;
            end
            if (wr_pt) begin
                points_x[pt_idx] <= s_x;
                points_y[pt_idx] <= s_y;
            end
            frame_err_q <= err_nxt;
            if (busy_clr)      busy_q <= 1'b0;
            else if (busy_set) busy_q <= 1'b1;
        end
    end

    assign frame_err = frame_err_q;
    assign busy      = busy_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_isodata_point_loader.sv
// Bench for isodata_point_loader with 2 centers and 4 points per frame.
// Frame outcomes come from a frame-level model: beats up to the frame length are stored, only an exact-length frame starts.
module tb_isodata_point_loader;
    import isodata_pkg::*;

    localparam int W  = 16;
    localparam int NP = 4;
    localparam int NC = 2;
    localparam int FL = NC + NP;

    logic                  clk, rst;
    logic                  s_valid, s_ready, s_last;
    logic [W-1:0]          s_x, s_y;
    logic [NC-1:0][W-1:0]  centers_x, centers_y;
    logic [NP-1:0][W-1:0]  points_x, points_y;
    logic                  acc_start, acc_done, busy, frame_err;
    state_t                dbg_state;

    isodata_point_loader #(.DATA_WIDTH(W), .NUM_POINTS(NP), .NUM_CLUSTERS(NC)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_y(s_y), .s_last(s_last),
        .centers_x(centers_x), .centers_y(centers_y),
        .points_x(points_x), .points_y(points_y),
        .acc_start(acc_start), .acc_done(acc_done), .busy(busy), .frame_err(frame_err),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int start_cnt = 0;
    int err_cnt   = 0;

    logic [W-1:0] m_cx[NC], m_cy[NC], m_px[NP], m_py[NP];

    always @(negedge clk) begin
        if (!rst) begin
            if (acc_start) start_cnt++;
            if (frame_err) err_cnt++;
        end
    end

    typedef struct {
        int last_at;
        bit gap;
        int base;
        bit exp_start;
        bit exp_err;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_clear();
        for (int i = 0; i < NC; i++) begin m_cx[i] = '0; m_cy[i] = '0; end
        for (int i = 0; i < NP; i++) begin m_px[i] = '0; m_py[i] = '0; end
    endtask

    // Beat number n (1-based) of a frame lands in centers first, then points.
    task automatic model_write(input int n, input logic [W-1:0] x, input logic [W-1:0] y);
        if (n <= NC) begin m_cx[n-1] = x; m_cy[n-1] = y; end
        else begin m_px[n-NC-1] = x; m_py[n-NC-1] = y; end
    endtask

    task automatic check_arrays(input string tag);
        for (int i = 0; i < NC; i++) begin
            check($sformatf("%s_cx%0d", tag, i), 32'(centers_x[i]), 32'(m_cx[i]));
            check($sformatf("%s_cy%0d", tag, i), 32'(centers_y[i]), 32'(m_cy[i]));
        end
        for (int i = 0; i < NP; i++) begin
            check($sformatf("%s_px%0d", tag, i), 32'(points_x[i]), 32'(m_px[i]));
            check($sformatf("%s_py%0d", tag, i), 32'(points_y[i]), 32'(m_py[i]));
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat transferred.
    task automatic send_beat(input logic [W-1:0] x, input logic [W-1:0] y, input bit last);
        int waited = 0;
        s_valid = 1'b1; s_x = x; s_y = y; s_last = last;
        while (!s_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!s_ready) check("s_ready_wait", 32'(s_ready), 32'd1);
        else begin
            @(posedge clk);
            @(negedge clk);
        end
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic send_frame(input string tag, input int last_at, input bit gap, input bit rnd,
                              input int base, input bit exp_start, input bit exp_err);
        logic [W-1:0] xs[16], ys[16];
        int s0, e0, k;
        s0 = start_cnt;
        e0 = err_cnt;
        for (int i = 1; i <= last_at; i++) begin
            if (rnd) begin xs[i] = W'($urandom); ys[i] = W'($urandom); end
            else begin xs[i] = W'(base + i); ys[i] = W'(10 * (base + i)); end
        end
        k = (last_at < FL) ? last_at : FL;
        for (int i = 1; i <= k; i++) model_write(i, xs[i], ys[i]);
        for (int i = 1; i <= last_at; i++) begin
            if (gap) @(negedge clk);
            send_beat(xs[i], ys[i], i == last_at);
            if (i == k) begin
                check({tag, "_start_at_end"}, 32'(acc_start), 32'(exp_start));
                check({tag, "_err_at_end"}, 32'(frame_err), 32'(exp_err));
            end
        end
        if (exp_start) begin
            @(negedge clk);
            check({tag, "_ready_wait"}, 32'(s_ready), 32'd0);
            check({tag, "_start_once"}, 32'(acc_start), 32'd0);
            check({tag, "_busy_wait"}, 32'(busy), 32'd1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            check({tag, "_ready_hold"}, 32'(s_ready), 32'd0);
            acc_done = 1'b1;
            @(negedge clk);
            acc_done = 1'b0;
            check({tag, "_busy_drop"}, 32'(busy), 32'd0);
            check({tag, "_ready_back"}, 32'(s_ready), 32'd1);
        end else begin
            @(negedge clk);
            check({tag, "_err_single"}, 32'(frame_err), 32'd0);
            check({tag, "_ready_idle"}, 32'(s_ready), 32'd1);
        end
        check({tag, "_start_count"}, 32'(start_cnt - s0), 32'(exp_start));
        check({tag, "_err_count"}, 32'(err_cnt - e0), 32'(exp_err));
        check_arrays(tag);
    endtask

    initial begin
        int s0, last_at;
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_x = '0; s_y = '0; acc_done = 1'b0;
        model_clear();

        vecs[0] = '{last_at: 6, gap: 0, base: 0,  exp_start: 1, exp_err: 0};
        vecs[1] = '{last_at: 6, gap: 1, base: 0,  exp_start: 1, exp_err: 0};
        vecs[2] = '{last_at: 3, gap: 0, base: 0,  exp_start: 0, exp_err: 1};
        vecs[3] = '{last_at: 6, gap: 0, base: 40, exp_start: 1, exp_err: 0};
        vecs[4] = '{last_at: 8, gap: 0, base: 50, exp_start: 0, exp_err: 1};
        vecs[5] = '{last_at: 6, gap: 1, base: 60, exp_start: 1, exp_err: 0};
        vecs[6] = '{last_at: 1, gap: 0, base: 70, exp_start: 0, exp_err: 1};
        vecs[7] = '{last_at: 2, gap: 1, base: 80, exp_start: 0, exp_err: 1};
        vecs[8] = '{last_at: 7, gap: 0, base: 90, exp_start: 0, exp_err: 1};

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start", 32'(acc_start), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(s_ready), 32'd1);
        check("rst_state", 32'(dbg_state), 32'(LOAD_CTR));
        check_arrays("rst");

        for (int v = 0; v < 9; v++)
            send_frame($sformatf("vec%0d", v), vecs[v].last_at, vecs[v].gap, 1'b0,
                       vecs[v].base, vecs[v].exp_start, vecs[v].exp_err);

        // acc_done while loading and in the start cycle must be ignored; reset in WAIT_DONE aborts.
        s0 = start_cnt;
        for (int i = 1; i <= 3; i++) begin
            model_write(i, W'(100 + i), W'(200 + i));
            send_beat(W'(100 + i), W'(200 + i), 1'b0);
        end
        acc_done = 1'b1;
        @(negedge clk);
        acc_done = 1'b0;
        check("spur_ready", 32'(s_ready), 32'd1);
        check("spur_err", 32'(frame_err), 32'd0);
        for (int i = 4; i <= FL; i++) begin
            model_write(i, W'(100 + i), W'(200 + i));
            send_beat(W'(100 + i), W'(200 + i), i == FL);
        end
        check("spur_start", 32'(acc_start), 32'd1);
        check_arrays("spur");
        acc_done = 1'b1;
        @(negedge clk);
        acc_done = 1'b0;
        check("kick_done_ignored", 32'(s_ready), 32'd0);
        @(negedge clk);
        check("kick_done_busy", 32'(busy), 32'd1);
        check("kick_done_ready", 32'(s_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready", 32'(s_ready), 32'd1);
        check("midrst_start", 32'(acc_start), 32'd0);
        check("midrst_err", 32'(frame_err), 32'd0);
        check("midrst_start_count", 32'(start_cnt - s0), 32'd1);
        check_arrays("midrst");
        send_frame("after_rst", FL, 1'b0, 1'b0, 120, 1'b1, 1'b0);

        for (int r = 0; r < 20; r++) begin
            last_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, FL + 3)) : FL;
            send_frame($sformatf("rnd%0d", r), last_at, 1'($urandom_range(0, 1)), 1'b1, 0,
                       last_at == FL, last_at != FL);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
